ram_arbiter: RTL



---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the two-port RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface ram_arbiter_if;
  logic        p0_req_in;
  logic [12:0] p0_address_in;
  logic        p0_ready_out;
  logic [63:0] p0_data_out;

  logic        p1_req_in;
  logic        p1_write_in;
  logic [12:0] p1_address_in;
  logic [1:0]  p1_size_in;
  logic [63:0] p1_value_in;
  logic        p1_ready_out;
  logic [63:0] p1_data_out;
  logic        p1_error_out;

  logic [9:0]  ram_address_out;
  logic [63:0] ram_value_out;
  logic [7:0]  ram_mask_out;
  logic        ram_write_signal_out;
  logic        ram_read_signal_out;
  logic [63:0] ram_data_read_value_in;

  modport slave (
    input  p0_req_in, p0_address_in,
    output p0_ready_out, p0_data_out,
    input  p1_req_in, p1_write_in, p1_address_in, p1_size_in, p1_value_in,
    output p1_ready_out, p1_data_out, p1_error_out,
    output ram_address_out, ram_value_out, ram_mask_out,
    output ram_write_signal_out, ram_read_signal_out,
    input  ram_data_read_value_in
  );

  modport master (
    output p0_req_in, p0_address_in,
    input  p0_ready_out, p0_data_out,
    output p1_req_in, p1_write_in, p1_address_in, p1_size_in, p1_value_in,
    input  p1_ready_out, p1_data_out, p1_error_out,
    input  ram_address_out, ram_value_out, ram_mask_out,
    input  ram_write_signal_out, ram_read_signal_out,
    output ram_data_read_value_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one 64-bit x 1024-word RAM port
// between instruction fetch (port 0) and load/store (port 1).
module ram_arbiter (
  input logic           clk_in,
  input logic           reset_in,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        mis_q, mis_d;
  logic [9:0]  ram_addr_q, ram_addr_d;
  logic [63:0] ram_val_q, ram_val_d;
  logic        p0_ready_q, p0_ready_d;
  logic        p1_ready_q, p1_ready_d;
  logic        p1_err_q, p1_err_d;
  logic [63:0] p0_data_q, p0_data_d;
  logic [63:0] p1_data_q, p1_data_d;

  logic        gnt1;
  logic [9:0]  sel_word;
  logic [2:0]  sel_off;
  logic [1:0]  sel_size;
  logic        sel_wr;
  logic [63:0] sel_val;
  logic        sel_mis;
  logic [7:0]  byte_base;
  logic [63:0] bit_mask;
  logic [63:0] rd_shift;
  logic        in_access;
  logic        unused_p0_off;

  assign unused_p0_off = ^bus.p0_address_in[2:0];

  // Tie goes to the port not granted last; last_grant_q holds the last granted port id.
  assign gnt1     = bus.p1_req_in && (!bus.p0_req_in || !last_grant_q);
  assign sel_word = gnt1 ? bus.p1_address_in[12:3] : bus.p0_address_in[12:3];
  assign sel_off  = gnt1 ? bus.p1_address_in[2:0] : 3'd0;
  assign sel_size = gnt1 ? bus.p1_size_in : 2'd3;
  assign sel_wr   = gnt1 && bus.p1_write_in;
  assign sel_val  = gnt1 ? bus.p1_value_in : 64'd0;

  always_comb begin
    sel_mis = 1'b0;
    case (sel_size)
      2'd1:    sel_mis = sel_off[0];
      2'd2:    sel_mis = |sel_off[1:0];
      2'd3:    sel_mis = |sel_off;
      default: sel_mis = 1'b0;
    endcase
  end

  always_comb begin
    byte_base = 8'h01;
    bit_mask  = 64'h0000_0000_0000_00ff;
    unique case (size_q)
      2'd0: begin byte_base = 8'h01; bit_mask = 64'h0000_0000_0000_00ff; end
      2'd1: begin byte_base = 8'h03; bit_mask = 64'h0000_0000_0000_ffff; end
      2'd2: begin byte_base = 8'h0f; bit_mask = 64'h0000_0000_ffff_ffff; end
      2'd3: begin byte_base = 8'hff; bit_mask = 64'hffff_ffff_ffff_ffff; end
    endcase
  end

  assign rd_shift = bus.ram_data_read_value_in >> {off_q, 3'b000};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    off_d        = off_q;
    size_d       = size_q;
    wr_d         = wr_q;
    mis_d        = mis_q;
    ram_addr_d   = ram_addr_q;
    ram_val_d    = ram_val_q;
    p0_ready_d   = 1'b0;
    p1_ready_d   = 1'b0;
    p1_err_d     = 1'b0;
    p0_data_d    = 64'd0;
    p1_data_d    = 64'd0;
    unique case (state_q)
      StIdle: begin
        if (bus.p0_req_in || bus.p1_req_in) begin
          last_grant_d = gnt1;
          port_d       = gnt1;
          off_d        = sel_off;
          size_d       = sel_size;
          wr_d         = sel_wr;
          mis_d        = sel_mis;
          ram_addr_d   = sel_word;
          ram_val_d    = sel_val << {sel_off, 3'b000};
          state_d      = StAccess;
        end
      end
      StAccess: begin
        // RAM read data is valid by the end of the access cycle; register the response here.
        if (!port_q) begin
          p0_ready_d = 1'b1;
          p0_data_d  = bus.ram_data_read_value_in;
        end else begin
          p1_ready_d = 1'b1;
          p1_err_d   = mis_q;
          p1_data_d  = (mis_q || wr_q) ? 64'd0 : (rd_shift & bit_mask);
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      off_q        <= 3'd0;
      size_q       <= 2'd0;
      wr_q         <= 1'b0;
      mis_q        <= 1'b0;
      ram_addr_q   <= 10'd0;
      ram_val_q    <= 64'd0;
      p0_ready_q   <= 1'b0;
      p1_ready_q   <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_data_q    <= 64'd0;
      p1_data_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      off_q        <= off_d;
      size_q       <= size_d;
      wr_q         <= wr_d;
      mis_q        <= mis_d;
      ram_addr_q   <= ram_addr_d;
      ram_val_q    <= ram_val_d;
      p0_ready_q   <= p0_ready_d;
      p1_ready_q   <= p1_ready_d;
      p1_err_q     <= p1_err_d;
      p0_data_q    <= p0_data_d;
      p1_data_q    <= p1_data_d;
    end
  end

  // Reset gates the strobes immediately so an access in flight cannot write.
  assign in_access                = (state_q == StAccess) && !reset_in;
  assign bus.ram_read_signal_out  = in_access && !mis_q && !wr_q;
  assign bus.ram_write_signal_out = in_access && !mis_q && wr_q;
  assign bus.ram_mask_out         = in_access ? (byte_base << off_q) : 8'd0;
  assign bus.ram_address_out      = ram_addr_q;
  assign bus.ram_value_out        = ram_val_q;
  assign bus.p0_ready_out         = p0_ready_q;
  assign bus.p0_data_out          = p0_data_q;
  assign bus.p1_ready_out         = p1_ready_q;
  assign bus.p1_data_out          = p1_data_q;
  assign bus.p1_error_out         = p1_err_q;

endmodule
